// File: rtl/cv32e40x_xif_aes_sched.sv
// rtl/cv32e40x_xif_aes_sched.sv - XIF issue/commit/result scheduler for one shared saes32 unit
// Holds offloaded AES32 instructions in issue order and runs committed ones through the FU one at a time.
module cv32e40x_xif_aes_sched #(
    parameter int DEPTH       = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFR_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [31:0]              issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]    issue_id_i,
    input  logic [2*X_RFR_WIDTH-1:0] issue_rs_i,
    input  logic [1:0]               issue_rs_valid_i,
    output logic                     issue_accept_o,
    input  logic                     commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]    commit_id_i,
    input  logic                     commit_kill_i,
    output logic                     fu_valid_o,
    output logic [X_RFR_WIDTH-1:0]   fu_rs1_o,
    output logic [X_RFR_WIDTH-1:0]   fu_rs2_o,
    output logic [1:0]               fu_bs_o,
    output logic [3:0]               fu_op_o,
    input  logic [X_RFR_WIDTH-1:0]   fu_rd_i,
    input  logic                     fu_ready_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [X_RFR_WIDTH-1:0]   result_data_o,
    output logic [X_ID_WIDTH-1:0]    result_id_o,
    output logic [4:0]               result_rd_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // AES32 instructions are offloaded on the custom-0 major opcode
    localparam logic [6:0] OPC_AES32  = 7'b0001011;
    localparam logic [4:0] F5_ESI     = 5'b10001;
    localparam logic [4:0] F5_ESMI    = 5'b10011;
    localparam logic [4:0] F5_DSI     = 5'b10101;
    localparam logic [4:0] F5_DSMI    = 5'b10111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DEPTH-1:0]       ent_valid;
    logic [DEPTH-1:0]       ent_committed;
    logic [DEPTH-1:0]       ent_killed;
    logic [X_ID_WIDTH-1:0]  ent_id  [DEPTH];
    logic [X_RFR_WIDTH-1:0] ent_rs1 [DEPTH];
    logic [X_RFR_WIDTH-1:0] ent_rs2 [DEPTH];
    logic [1:0]             ent_bs  [DEPTH];
    logic [3:0]             ent_op  [DEPTH];
    logic [4:0]             ent_rd  [DEPTH];

    logic [AW:0]   head_ptr, tail_ptr;
    logic [AW-1:0] head_idx, tail_idx;
    logic          full;
    logic          id_hit;
    logic          push, pop, latch_result;
    logic          push_hit;
    logic          head_commit_now;
    logic [3:0]    dec_op;
    logic          is_aes;
    logic          unused_instr_bits;

    assign unused_instr_bits = ^issue_instr_i[24:12];

    assign head_idx = head_ptr[AW-1:0];
    assign tail_idx = tail_ptr[AW-1:0];
    assign full     = (head_ptr[AW] != tail_ptr[AW]) && (head_idx == tail_idx);

    always_comb begin
        dec_op = 4'b0000;
        case (issue_instr_i[29:25])
            F5_ESMI: dec_op = 4'b1000;
            F5_ESI:  dec_op = 4'b0100;
            F5_DSMI: dec_op = 4'b0010;
            F5_DSI:  dec_op = 4'b0001;
            default: dec_op = 4'b0000;
        endcase
    end

    assign is_aes = (issue_instr_i[6:0] == OPC_AES32) && (dec_op != 4'b0000);

    always_comb begin
        id_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_id[i] == issue_id_i)) begin
                id_hit = 1'b1;
            end
        end
    end

    assign issue_ready_o  = !full && !id_hit;
    assign push           = issue_valid_i && is_aes && (issue_rs_valid_i == 2'b11) && issue_ready_o;
    assign issue_accept_o = push;
    assign push_hit       = commit_valid_i && (commit_id_i == issue_id_i);

    // Looking at this cycle's commit lets dispatch start the cycle right after commit
    always_comb begin
        head_commit_now = 1'b0;
        if (ent_valid[head_idx]) begin
            head_commit_now = ent_committed[head_idx] ||
                              (commit_valid_i && !commit_kill_i && !ent_killed[head_idx] &&
                               (ent_id[head_idx] == commit_id_i));
        end else begin
            head_commit_now = push && push_hit && !commit_kill_i;
        end
    end

    always_comb begin
        state_next     = state;
        pop            = 1'b0;
        latch_result   = 1'b0;
        fu_valid_o     = 1'b0;
        result_valid_o = 1'b0;
        case (state)
            IDLE: begin
                if (ent_valid[head_idx] && ent_killed[head_idx]) begin
                    pop = 1'b1;
                end else if (head_commit_now) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                fu_valid_o = 1'b1;
                if (fu_ready_i) begin
                    latch_result = 1'b1;
                    state_next   = RESP;
                end
            end
            RESP: begin
                result_valid_o = 1'b1;
                if (result_ready_i) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign fu_rs1_o = fu_valid_o ? ent_rs1[head_idx] : '0;
    assign fu_rs2_o = fu_valid_o ? ent_rs2[head_idx] : '0;
    assign fu_bs_o  = fu_valid_o ? ent_bs[head_idx]  : 2'b00;
    assign fu_op_o  = fu_valid_o ? ent_op[head_idx]  : 4'b0000;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid     <= '0;
            ent_committed <= '0;
            ent_killed    <= '0;
            head_ptr      <= '0;
            tail_ptr      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && ent_valid[i] && (ent_id[i] == commit_id_i) &&
                    !ent_committed[i] && !ent_killed[i]) begin
                    if (commit_kill_i) begin
                        ent_killed[i] <= 1'b1;
                    end else begin
                        ent_committed[i] <= 1'b1;
                    end
                end
            end
            if (pop) begin
                ent_valid[head_idx]     <= 1'b0;
                ent_committed[head_idx] <= 1'b0;
                ent_killed[head_idx]    <= 1'b0;
                head_ptr                <= head_ptr + PTR_ONE;
            end
            if (push) begin
                ent_valid[tail_idx]     <= 1'b1;
                ent_committed[tail_idx] <= push_hit && !commit_kill_i;
                ent_killed[tail_idx]    <= push_hit && commit_kill_i;
                tail_ptr                <= tail_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            ent_id[tail_idx]  <= issue_id_i;
            ent_rs1[tail_idx] <= issue_rs_i[X_RFR_WIDTH-1:0];
            ent_rs2[tail_idx] <= issue_rs_i[2*X_RFR_WIDTH-1:X_RFR_WIDTH];
            ent_bs[tail_idx]  <= issue_instr_i[31:30];
            ent_op[tail_idx]  <= dec_op;
            ent_rd[tail_idx]  <= issue_instr_i[11:7];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            result_data_o <= '0;
            result_id_o   <= '0;
            result_rd_o   <= '0;
        end else if (latch_result) begin
            result_data_o <= fu_rd_i;
            result_id_o   <= ent_id[head_idx];
            result_rd_o   <= ent_rd[head_idx];
        end
    end

endmodule
